// File: rtl/reg_incr_pkg.sv
// rtl/reg_incr_pkg.sv - shared constants for the increment pipeline
package reg_incr_pkg;

    // Overflow handling selected by p_saturate
    localparam int WRAP     = 0;
    localparam int SATURATE = 1;

endpackage

// File: rtl/reg_incr_pipe_if.sv
// rtl/reg_incr_pipe_if.sv - val/rdy upstream and downstream ports of the increment pipeline
interface reg_incr_pipe_if #(
    parameter int p_nbits = 8
);
    logic               in_val;
    logic               in_rdy;
    logic [p_nbits-1:0] in_msg;
    logic               out_val;
    logic               out_rdy;
    logic [p_nbits-1:0] out_msg;
    logic               out_ovf;

    // Producer/consumer side that feeds the pipeline and drains its results
    modport master (
        output in_val, in_msg, out_rdy,
        input  in_rdy, out_val, out_msg, out_ovf
    );

    // The pipeline itself
    modport slave (
        input  in_val, in_msg, out_rdy,
        output in_rdy, out_val, out_msg, out_ovf
    );
endinterface

// File: rtl/reg_incr_pipe_stage.sv
// rtl/reg_incr_pipe_stage.sv - one registered add-and-overflow stage
module reg_incr_pipe_stage
    import reg_incr_pkg::*;
#(
    parameter int          p_nbits    = 8,
    parameter logic [63:0] p_incr     = 64'd1,
    parameter int          p_saturate = WRAP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               up_val,
    input  logic [p_nbits-1:0] up_data,
    input  logic               up_ovf,
    output logic               val,
    output logic [p_nbits-1:0] data,
    output logic               ovf
);

    localparam logic [p_nbits-1:0] incr = p_incr[p_nbits-1:0];

    logic [p_nbits:0]   sum;
    logic               carry;
    logic [p_nbits-1:0] result;

    // Widened add so the carry-out doubles as the overflow flag in both modes
    always_comb begin
        sum    = {1'b0, up_data} + {1'b0, incr};
        carry  = sum[p_nbits];
        result = sum[p_nbits-1:0];
        if (p_saturate == SATURATE && carry) begin
            result = '1;
        end
    end

    // Load on demand; an empty upstream clears valid but leaves data/ovf as they were
    always_ff @(posedge clk) begin
        if (reset) begin
            val  <= 1'b0;
            data <= '0;
            ovf  <= 1'b0;
        end else if (load) begin
            val <= up_val;
            if (up_val) begin
                data <= result;
                ovf  <= up_ovf | carry;
            end
        end
    end

endmodule

// File: rtl/reg_incr_pipe.sv
// rtl/reg_incr_pipe.sv - elastic pipeline adding p_incr per stage with wrap or saturate
module reg_incr_pipe
    import reg_incr_pkg::*;
#(
    parameter int          p_nbits    = 8,
    parameter int          p_nstages  = 2,
    parameter logic [63:0] p_incr     = 64'd1,
    parameter int          p_saturate = WRAP
) (
    input  logic           clk,
    input  logic           reset,
    reg_incr_pipe_if.slave io
);

    logic [p_nstages-1:0]              st_val;
    logic [p_nstages-1:0]              st_ovf;
    logic [p_nstages-1:0][p_nbits-1:0] st_data;
    logic [p_nstages-1:0]              load;

    // Stage k may load if the sink is ready or any stage from k onward has a bubble;
    // computed from registered valids only, so no combinational chain between stages
    always_comb begin
        load = '0;
        for (int k = 0; k < p_nstages; k++) begin
            load[k] = io.out_rdy;
            for (int j = k; j < p_nstages; j++) begin
                if (!st_val[j]) begin
                    load[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < p_nstages; k++) begin : g_stage
        logic               up_val;
        logic [p_nbits-1:0] up_data;
        logic               up_ovf;

        if (k == 0) begin : g_head
            assign up_val  = io.in_val;
            assign up_data = io.in_msg;
            assign up_ovf  = 1'b0;
        end else begin : g_body
            assign up_val  = st_val[k-1];
            assign up_data = st_data[k-1];
            assign up_ovf  = st_ovf[k-1];
        end

        reg_incr_pipe_stage #(
            .p_nbits    (p_nbits),
            .p_incr     (p_incr),
            .p_saturate (p_saturate)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .load    (load[k]),
            .up_val  (up_val),
            .up_data (up_data),
            .up_ovf  (up_ovf),
            .val     (st_val[k]),
            .data    (st_data[k]),
            .ovf     (st_ovf[k])
        );
    end

    // Outputs are forced quiet while reset is held so neither port can transfer
    always_comb begin
        io.in_rdy  = !reset && load[0];
        io.out_val = !reset && st_val[p_nstages-1];
        io.out_msg = reset ? '0 : st_data[p_nstages-1];
        io.out_ovf = !reset && st_ovf[p_nstages-1];
    end

`ifndef SYNTHESIS
    function automatic string line_trace();
        string s;
        s = $sformatf("%h |", io.in_msg);
        for (int k = 0; k < p_nstages; k++) begin
            s = {s, $sformatf(" %s%h", st_val[k] ? "*" : ".", st_data[k])};
        end
        s = {s, $sformatf(" | %h", io.out_msg)};
        return s;
    endfunction
`endif

endmodule

// File: tb/tb_reg_incr_pipe.sv
// tb/tb_reg_incr_pipe.sv - directed and scoreboard checks of reg_incr_pipe
module tb_reg_incr_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0]       in_val_a;
    logic [4:0]       out_rdy_a;
    logic [4:0][15:0] in_msg_a;
    logic [4:0]       in_rdy_w;
    logic [4:0]       out_val_w;
    logic [4:0]       out_ovf_w;
    logic [4:0][15:0] out_msg_w;

    int n_tests = 0;
    int n_fail  = 0;

    // 0: 8b/2st/+1 wrap, 1: 8b/2st/+1 sat, 2: 8b/2st/+0 wrap,
    // 3: 16b/4st/+0x4000 wrap, 4: 16b/4st/+0x4000 sat
    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int          NB  = (g >= 3) ? 16 : 8;
        localparam int          NS  = (g >= 3) ? 4 : 2;
        localparam logic [63:0] INC = (g == 2) ? 64'd0 : ((g >= 3) ? 64'h4000 : 64'd1);
        localparam int          SAT = (g == 1 || g == 4) ? 1 : 0;

        reg_incr_pipe_if #(.p_nbits(NB)) io ();

        assign io.in_val     = in_val_a[g];
        assign io.in_msg     = in_msg_a[g][NB-1:0];
        assign io.out_rdy    = out_rdy_a[g];
        assign in_rdy_w[g]   = io.in_rdy;
        assign out_val_w[g]  = io.out_val;
        assign out_ovf_w[g]  = io.out_ovf;
        assign out_msg_w[g]  = 16'(io.out_msg);

        reg_incr_pipe #(
            .p_nbits    (NB),
            .p_nstages  (NS),
            .p_incr     (INC),
            .p_saturate (SAT)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .io    (io)
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input int d, input logic v, input logic [15:0] m, input logic r);
        in_val_a[d]  = v;
        in_msg_a[d]  = m;
        out_rdy_a[d] = r;
    endtask

    // One isolated message through DUT d with the sink always ready
    task automatic single(input int d, input int lat, input logic [15:0] m,
                          input logic [15:0] em, input logic eo, input string tag);
        next_cyc();
        drv(d, 1'b1, m, 1'b1);
        #1;
        check({tag, " in_rdy"}, in_rdy_w[d], 1);
        for (int c = 1; c < lat; c++) begin
            next_cyc();
            drv(d, 1'b0, 16'h0, 1'b1);
            #1;
            check({tag, " early out_val"}, out_val_w[d], 0);
        end
        next_cyc();
        drv(d, 1'b0, 16'h0, 1'b1);
        #1;
        check({tag, " out_val"}, out_val_w[d], 1);
        check({tag, " out_msg"}, out_msg_w[d], em);
        check({tag, " out_ovf"}, out_ovf_w[d], eo);
    endtask

    // Reference for the 16b/4-stage/+0x4000 configurations: {ovf, data}
    function automatic logic [16:0] model(input logic [15:0] m, input bit sat);
        longint d;
        longint s;
        logic   o;
        d = longint'(m);
        o = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s = d + 64'h4000;
            if (s > 64'hFFFF) begin
                o = 1'b1;
                d = sat ? 64'hFFFF : s - 64'h10000;
            end else begin
                d = s;
            end
        end
        return {o, d[15:0]};
    endfunction

    logic [16:0] sbq [5][$];
    int          sent [5];
    bit          hold [5];
    logic [16:0] exp_v;

    initial begin
        in_val_a  = '0;
        in_msg_a  = '0;
        out_rdy_a = '1;
        reset     = 1'b1;

        // Reset: outputs quiet even with a message offered
        next_cyc();
        in_val_a[0] = 1'b1;
        #1;
        check("rst in_rdy", in_rdy_w[0], 0);
        check("rst out_val", out_val_w[0], 0);
        check("rst out_msg", out_msg_w[0], 0);
        check("rst out_ovf", out_ovf_w[0], 0);
        check("rst in_rdy d4", in_rdy_w[4], 0);
        next_cyc();
        next_cyc();
        reset       = 1'b0;
        in_val_a[0] = 1'b0;
        #1;
        check("post-rst in_rdy", in_rdy_w[0], 1);
        check("post-rst out_val", out_val_w[0], 0);

        // Single messages, latency and overflow boundaries
        single(0, 2, 16'h05, 16'h07, 1'b0, "basic");
        single(0, 2, 16'hFF, 16'h01, 1'b1, "wrap ff");
        single(0, 2, 16'hFE, 16'h00, 1'b1, "wrap fe");
        single(0, 2, 16'hFD, 16'hFF, 1'b0, "wrap fd");
        single(1, 2, 16'hFE, 16'hFF, 1'b1, "sat fe");
        single(1, 2, 16'hFD, 16'hFF, 1'b0, "sat fd");
        single(1, 2, 16'h40, 16'h42, 1'b0, "sat mid");
        single(2, 2, 16'hA5, 16'hA5, 1'b0, "incr0 a5");
        single(2, 2, 16'hFF, 16'hFF, 1'b0, "incr0 ff");
        single(3, 4, 16'h0123, 16'h0123, 1'b1, "w16 0123");
        single(4, 4, 16'h0001, 16'hFFFF, 1'b1, "s16 0001");

        // Back-to-back stream at full throughput
        for (int i = 0; i < 12; i++) begin
            next_cyc();
            drv(0, i < 10, 16'(i), 1'b1);
            #1;
            if (i < 10) check("stream in_rdy", in_rdy_w[0], 1);
            if (i >= 2) begin
                check("stream out_val", out_val_w[0], 1);
                check("stream out_msg", out_msg_w[0], 16'(i));
            end else begin
                check("stream fill out_val", out_val_w[0], 0);
            end
        end

        // Backpressure: two accepted, third stalls, then all drain in order
        next_cyc(); drv(0, 1'b1, 16'h10, 1'b0); #1;
        check("bp in_rdy 0", in_rdy_w[0], 1);
        next_cyc(); drv(0, 1'b1, 16'h11, 1'b0); #1;
        check("bp in_rdy 1", in_rdy_w[0], 1);
        for (int c = 0; c < 3; c++) begin
            next_cyc(); drv(0, 1'b1, 16'h12, 1'b0); #1;
            check("bp stall in_rdy", in_rdy_w[0], 0);
            check("bp stall out_val", out_val_w[0], 1);
            check("bp stall out_msg", out_msg_w[0], 16'h12);
        end
        next_cyc(); drv(0, 1'b1, 16'h12, 1'b1); #1;
        check("bp release in_rdy", in_rdy_w[0], 1);
        check("bp out 0", out_msg_w[0], 16'h12);
        next_cyc(); drv(0, 1'b0, 16'h0, 1'b1); #1;
        check("bp out 1 val", out_val_w[0], 1);
        check("bp out 1", out_msg_w[0], 16'h13);
        next_cyc(); #1;
        check("bp out 2 val", out_val_w[0], 1);
        check("bp out 2", out_msg_w[0], 16'h14);
        next_cyc(); #1;
        check("bp empty", out_val_w[0], 0);

        // Reset with two messages in flight
        next_cyc(); drv(0, 1'b1, 16'h20, 1'b1);
        next_cyc(); drv(0, 1'b1, 16'h21, 1'b1);
        next_cyc(); drv(0, 1'b0, 16'h0, 1'b1); reset = 1'b1; #1;
        check("midrst out_val", out_val_w[0], 0);
        check("midrst in_rdy", in_rdy_w[0], 0);
        next_cyc(); reset = 1'b0; #1;
        check("midrst next out_val", out_val_w[0], 0);
        check("midrst next in_rdy", in_rdy_w[0], 1);
        for (int c = 0; c < 4; c++) begin
            next_cyc(); #1;
            check("midrst no stale", out_val_w[0], 0);
        end

        // Random val/rdy traffic on both 16-bit configurations against a queue model
        begin
            int cyc;
            cyc = 0;
            for (int d = 3; d <= 4; d++) begin
                sent[d] = 0;
                hold[d] = 1'b0;
            end
            while ((sent[3] < 1000 || sent[4] < 1000 || sbq[3].size() > 0 || sbq[4].size() > 0)
                   && cyc < 20000) begin
                next_cyc();
                cyc++;
                for (int d = 3; d <= 4; d++) begin
                    if (!hold[d]) begin
                        if (sent[d] < 1000 && $urandom_range(0, 9) < 7) begin
                            in_val_a[d] = 1'b1;
                            in_msg_a[d] = 16'($urandom);
                        end else begin
                            in_val_a[d] = 1'b0;
                        end
                    end
                    out_rdy_a[d] = ($urandom_range(0, 9) < 6);
                end
                #1;
                for (int d = 3; d <= 4; d++) begin
                    if (in_val_a[d] && in_rdy_w[d]) begin
                        sbq[d].push_back(model(in_msg_a[d], d == 4));
                        sent[d]++;
                        hold[d] = 1'b0;
                    end else begin
                        hold[d] = in_val_a[d];
                    end
                    if (out_val_w[d] && out_rdy_a[d]) begin
                        if (sbq[d].size() == 0) begin
                            check("rnd spurious output", 1, 0);
                        end else begin
                            exp_v = sbq[d].pop_front();
                            check(d == 4 ? "rnd sat msg" : "rnd wrap msg", out_msg_w[d], exp_v[15:0]);
                            check(d == 4 ? "rnd sat ovf" : "rnd wrap ovf", out_ovf_w[d], exp_v[16]);
                        end
                    end
                end
            end
            check("rnd completed in budget", cyc < 20000, 1);
            check("rnd wrap sent", sent[3], 1000);
            check("rnd sat sent", sent[4], 1000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
